// File: rtl/pusch_dr_sched.sv
// rtl/pusch_dr_sched.sv - Lock-step symbol read scheduler for the PUSCH dimension-reduction input
// Optional gather-timeout drop path: define PUSCH_DR_SCHED_TIMEOUT_EN.
module pusch_dr_sched #(
    parameter int LANE    = 8,
    parameter int ADDR_W  = 11,
    parameter int RE_NUM  = 1584,
    parameter int TIMEOUT = 4095
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [LANE-1:0]   i_lane_mask,
    input  logic [1:0]        i_dr_mode,
    input  logic [LANE-1:0]   i_lane_rdy,
    input  logic [6:0]        i_slot_idx,
    input  logic [3:0]        i_symb_idx,
    input  logic              i_core_busy,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_vld,
    output logic              o_rd_sop,
    output logic              o_rd_last,
    output logic [LANE-1:0]   o_lane_ack,
    output logic              o_resort,
    output logic              o_timeout_err,
    output logic              o_ovf_err,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATHER,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RE_NUM - 1);

    state_t            state, state_nxt;
    logic [LANE-1:0]   pend;
    logic [LANE-1:0]   mask_q;
    logic [LANE-1:0]   ack_q, ack_nxt;
    logic [1:0]        mode_q;
    logic [6:0]        slot_q;
    logic [3:0]        symb_q;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              resort_done;
    logic              resort_q, resort_nxt, resort_pol;
    logic              tmo_q, tmo_nxt;
    logic              ovf_q;
    logic              rd_vld, at_last, pend_full, start, tmr_exp;

`ifdef PUSCH_DR_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q;

    // Expires on the cycle whose closing edge brings the count to TIMEOUT.
    assign tmr_exp = (tmr_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || state != S_GATHER) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmr_exp        = 1'b0;
`endif

    // A lane acked this cycle no longer counts as pending for a new start.
    assign start     = i_enable && (|i_lane_mask) && (|(pend & ~ack_q & i_lane_mask));
    assign pend_full = ((pend & mask_q) == mask_q);
    assign rd_vld    = (state == S_ISSUE) && !i_core_busy;
    assign at_last   = (addr_q == LAST_ADDR);

    always_comb begin
        resort_pol = 1'b0;
        case (mode_q)
            2'd0:    resort_pol = !resort_done;
            2'd1:    resort_pol = (slot_q == 7'd0) && (symb_q == 4'd0);
            2'd2:    resort_pol = (symb_q == 4'd0);
            default: resort_pol = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        ack_nxt    = '0;
        resort_nxt = 1'b0;
        tmo_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                addr_nxt = '0;
                if (start) begin
                    state_nxt = S_GATHER;
                end
            end
            S_GATHER: begin
                if (pend_full) begin
                    state_nxt = S_ISSUE;
                end else if (tmr_exp) begin
                    state_nxt = S_IDLE;
                    tmo_nxt   = 1'b1;
                    ack_nxt   = pend & mask_q;
                end
            end
            S_ISSUE: begin
                if (rd_vld) begin
                    if (at_last) begin
                        state_nxt  = S_DONE;
                        addr_nxt   = '0;
                        ack_nxt    = mask_q;
                        resort_nxt = resort_pol;
                    end else begin
                        addr_nxt = addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            pend        <= '0;
            mask_q      <= '0;
            mode_q      <= '0;
            slot_q      <= '0;
            symb_q      <= '0;
            addr_q      <= '0;
            ack_q       <= '0;
            resort_q    <= 1'b0;
            resort_done <= 1'b0;
            tmo_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            ack_q    <= ack_nxt;
            resort_q <= resort_nxt;
            tmo_q    <= tmo_nxt;
            ovf_q    <= |(i_lane_rdy & pend);
            // A new ready beats the release of the same lane.
            pend     <= (pend & ~ack_q) | i_lane_rdy;
            if (state == S_IDLE && start) begin
                mask_q <= i_lane_mask;
                mode_q <= i_dr_mode;
                slot_q <= i_slot_idx;
                symb_q <= i_symb_idx;
            end
            if (rd_vld && at_last) begin
                resort_done <= 1'b1;
            end
        end
    end

    assign o_rd_addr     = addr_q;
    assign o_rd_vld      = rd_vld;
    assign o_rd_sop      = rd_vld && (addr_q == '0);
    assign o_rd_last     = rd_vld && at_last;
    assign o_lane_ack    = ack_q;
    assign o_resort      = resort_q;
    assign o_timeout_err = tmo_q;
    assign o_ovf_err     = ovf_q;
    assign o_busy        = (state != S_IDLE);

endmodule

// File: tb/tb_pusch_dr_sched.sv
// tb/tb_pusch_dr_sched.sv - Directed self-checking bench for pusch_dr_sched
module tb_pusch_dr_sched;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic [7:0]  i_lane_mask;
    logic [1:0]  i_dr_mode;
    logic [7:0]  i_lane_rdy;
    logic [6:0]  i_slot_idx;
    logic [3:0]  i_symb_idx;
    logic        i_core_busy;
    logic [10:0] o_rd_addr;
    logic        o_rd_vld;
    logic        o_rd_sop;
    logic        o_rd_last;
    logic [7:0]  o_lane_ack;
    logic        o_resort;
    logic        o_timeout_err;
    logic        o_ovf_err;
    logic        o_busy;

    int errors;
    int checks;

    pusch_dr_sched #(
        .LANE   (8),
        .ADDR_W (11),
        .RE_NUM (1584),
        .TIMEOUT(100)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_lane_mask  (i_lane_mask),
        .i_dr_mode    (i_dr_mode),
        .i_lane_rdy   (i_lane_rdy),
        .i_slot_idx   (i_slot_idx),
        .i_symb_idx   (i_symb_idx),
        .i_core_busy  (i_core_busy),
        .o_rd_addr    (o_rd_addr),
        .o_rd_vld     (o_rd_vld),
        .o_rd_sop     (o_rd_sop),
        .o_rd_last    (o_rd_last),
        .o_lane_ack   (o_lane_ack),
        .o_resort     (o_resort),
        .o_timeout_err(o_timeout_err),
        .o_ovf_err    (o_ovf_err),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
    task automatic next_cycle;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        next_cycle();
        i_reset     = 1'b1;
        i_enable    = 1'b0;
        i_lane_mask = 8'h00;
        i_dr_mode   = 2'd3;
        i_lane_rdy  = 8'h00;
        i_slot_idx  = 7'd0;
        i_symb_idx  = 4'd0;
        i_core_busy = 1'b0;
        repeat (3) next_cycle();
        i_reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #2;
        checks += 7;
        if (o_rd_addr !== 11'd0)   begin errors++; $display("FAIL reset_addr: got %0d expected 0", o_rd_addr); end
        if (o_rd_vld !== 1'b0)     begin errors++; $display("FAIL reset_vld: got %b expected 0", o_rd_vld); end
        if (o_rd_sop !== 1'b0 || o_rd_last !== 1'b0) begin errors++; $display("FAIL reset_sop_last: got %b%b expected 00", o_rd_sop, o_rd_last); end
        if (o_lane_ack !== 8'h00)  begin errors++; $display("FAIL reset_ack: got %h expected 00", o_lane_ack); end
        if (o_resort !== 1'b0)     begin errors++; $display("FAIL reset_resort: got %b expected 0", o_resort); end
        if (o_timeout_err !== 1'b0 || o_ovf_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b expected 00", o_timeout_err, o_ovf_err); end
        if (o_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_basic_sweep;
        int sop_c, sop_a, last_c, last_a, ack_c, vld_n;
        logic [7:0] ack_v;
        do_reset();
        i_lane_mask = 8'hFF;
        i_enable    = 1'b1;
        sop_c = -1; sop_a = -1; last_c = -1; last_a = -1; ack_c = -1; vld_n = 0; ack_v = 8'h00;
        for (int c = 0; c < 1620; c++) begin
            next_cycle();
            i_lane_rdy = (c >= 10 && c <= 17) ? 8'(1 << (c - 10)) : 8'h00;
            #2;
            if (o_rd_vld) vld_n++;
            if (o_rd_sop && sop_c < 0) begin sop_c = c; sop_a = int'(o_rd_addr); end
            if (o_rd_last) begin last_c = c; last_a = int'(o_rd_addr); end
            if (o_lane_ack != 8'h00 && ack_c < 0) begin ack_c = c; ack_v = o_lane_ack; end
        end
        checks += 8;
        if (sop_c != 19)     begin errors++; $display("FAIL basic_sop_cycle: got %0d expected 19", sop_c); end
        if (sop_a != 0)      begin errors++; $display("FAIL basic_sop_addr: got %0d expected 0", sop_a); end
        if (last_c != 1602)  begin errors++; $display("FAIL basic_last_cycle: got %0d expected 1602", last_c); end
        if (last_a != 1583)  begin errors++; $display("FAIL basic_last_addr: got %0d expected 1583", last_a); end
        if (ack_c != 1603)   begin errors++; $display("FAIL basic_ack_cycle: got %0d expected 1603", ack_c); end
        if (ack_v !== 8'hFF) begin errors++; $display("FAIL basic_ack_value: got %h expected ff", ack_v); end
        if (vld_n != 1584)   begin errors++; $display("FAIL basic_vld_count: got %0d expected 1584", vld_n); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got %b expected 0", o_busy); end
    endtask

    task automatic test_stall;
        int hold_n, vld_n, last_c;
        logic [10:0] resume_addr;
        logic resume_vld;
        do_reset();
        i_lane_mask = 8'hFF;
        i_enable    = 1'b1;
        hold_n = 0; vld_n = 0; last_c = -1; resume_addr = '0; resume_vld = 1'b0;
        for (int c = 0; c < 1600; c++) begin
            next_cycle();
            i_lane_rdy  = (c == 0) ? 8'hFF : 8'h00;
            i_core_busy = (c >= 703 && c <= 707);
            #2;
            if (o_rd_vld) vld_n++;
            if (o_rd_last) last_c = c;
            if (c >= 703 && c <= 707 && o_rd_addr == 11'd700 && !o_rd_vld) hold_n++;
            if (c == 708) begin resume_addr = o_rd_addr; resume_vld = o_rd_vld; end
        end
        i_core_busy = 1'b0;
        checks += 4;
        if (hold_n != 5)     begin errors++; $display("FAIL stall_hold_cycles: got %0d expected 5", hold_n); end
        if (resume_addr !== 11'd700 || resume_vld !== 1'b1) begin errors++; $display("FAIL stall_resume: got addr %0d vld %b expected addr 700 vld 1", resume_addr, resume_vld); end
        if (vld_n != 1584)   begin errors++; $display("FAIL stall_vld_count: got %0d expected 1584", vld_n); end
        if (last_c != 1591)  begin errors++; $display("FAIL stall_last_cycle: got %0d expected 1591", last_c); end
    endtask

    task automatic test_overflow;
        int ovf_c, sop1_c, sop2_c;
        do_reset();
        i_lane_mask = 8'hFF;
        i_enable    = 1'b1;
        ovf_c = -1; sop1_c = -1; sop2_c = -1;
        for (int c = 0; c < 1600; c++) begin
            next_cycle();
            case (c)
                0, 3:    i_lane_rdy = 8'h04;
                5:       i_lane_rdy = 8'hFB;
                1591:    i_lane_rdy = 8'h01;
                1595:    i_lane_rdy = 8'hFE;
                default: i_lane_rdy = 8'h00;
            endcase
            #2;
            if (o_ovf_err && ovf_c < 0) ovf_c = c;
            if (o_rd_sop && c < 100 && sop1_c < 0) sop1_c = c;
            if (o_rd_sop && c >= 100 && sop2_c < 0) sop2_c = c;
        end
        checks += 3;
        if (ovf_c != 4)     begin errors++; $display("FAIL ovf_cycle: got %0d expected 4", ovf_c); end
        if (sop1_c != 7)    begin errors++; $display("FAIL ovf_first_sop: got %0d expected 7", sop1_c); end
        if (sop2_c != 1597) begin errors++; $display("FAIL done_rdy_next_sop: got %0d expected 1597", sop2_c); end
    endtask

    task automatic run_sym(input logic [6:0] slot, input logic [3:0] symb, output logic got);
        got = 1'b0;
        i_slot_idx = slot;
        i_symb_idx = symb;
        for (int c = 0; c < 1600; c++) begin
            next_cycle();
            i_lane_rdy = (c == 0) ? 8'hFF : 8'h00;
            #2;
            if (o_resort) got = 1'b1;
        end
    endtask

    task automatic test_resort;
        logic g0, g1, g2;
        do_reset();
        i_lane_mask = 8'hFF;
        i_enable    = 1'b1;
        i_dr_mode   = 2'd0;
        run_sym(7'd0, 4'd0, g0);
        run_sym(7'd1, 4'd3, g1);
        checks += 2;
        if (g0 !== 1'b1) begin errors++; $display("FAIL resort_mode0_first: got %b expected 1", g0); end
        if (g1 !== 1'b0) begin errors++; $display("FAIL resort_mode0_second: got %b expected 0", g1); end
        i_dr_mode = 2'd1;
        run_sym(7'd0, 4'd0, g0);
        run_sym(7'd0, 4'd1, g1);
        run_sym(7'd1, 4'd0, g2);
        checks += 3;
        if (g0 !== 1'b1) begin errors++; $display("FAIL resort_mode1_s0y0: got %b expected 1", g0); end
        if (g1 !== 1'b0) begin errors++; $display("FAIL resort_mode1_s0y1: got %b expected 0", g1); end
        if (g2 !== 1'b0) begin errors++; $display("FAIL resort_mode1_s1y0: got %b expected 0", g2); end
        i_dr_mode = 2'd2;
        run_sym(7'd0, 4'd0, g0);
        run_sym(7'd0, 4'd1, g1);
        run_sym(7'd1, 4'd0, g2);
        checks += 3;
        if (g0 !== 1'b1) begin errors++; $display("FAIL resort_mode2_s0y0: got %b expected 1", g0); end
        if (g1 !== 1'b0) begin errors++; $display("FAIL resort_mode2_s0y1: got %b expected 0", g1); end
        if (g2 !== 1'b1) begin errors++; $display("FAIL resort_mode2_s1y0: got %b expected 1", g2); end
    endtask

`ifdef PUSCH_DR_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        int err_c, vld_n;
        logic [7:0] ack_v;
        logic busy_v;
        do_reset();
        i_lane_mask = 8'h0F;
        i_enable    = 1'b1;
        i_dr_mode   = 2'd3;
        err_c = -1; vld_n = 0; ack_v = 8'h00; busy_v = 1'b1;
        for (int c = 0; c < 130; c++) begin
            next_cycle();
            i_lane_rdy = (c == 0) ? 8'h07 : 8'h00;
            #2;
            if (o_rd_vld) vld_n++;
            if (o_timeout_err && err_c < 0) begin err_c = c; ack_v = o_lane_ack; busy_v = o_busy; end
        end
        checks += 5;
        if (err_c != 102)     begin errors++; $display("FAIL timeout_cycle: got %0d expected 102", err_c); end
        if (ack_v !== 8'h07)  begin errors++; $display("FAIL timeout_ack: got %h expected 07", ack_v); end
        if (busy_v !== 1'b0)  begin errors++; $display("FAIL timeout_idle: got %b expected 0", busy_v); end
        if (vld_n != 0)       begin errors++; $display("FAIL timeout_no_vld: got %0d expected 0", vld_n); end
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL timeout_no_restart: got %b expected 0", o_busy); end
    endtask
`endif

    task automatic test_reset_mid_issue;
        logic [10:0] pre_addr;
        logic pre_vld;
        int restart_n;
        do_reset();
        i_lane_mask = 8'hFF;
        i_enable    = 1'b1;
        pre_addr = '0; pre_vld = 1'b0; restart_n = 0;
        for (int c = 0; c < 504; c++) begin
            next_cycle();
            i_lane_rdy = (c == 0) ? 8'hFF : 8'h00;
            i_reset    = (c == 503);
            #2;
            if (c == 503) begin pre_addr = o_rd_addr; pre_vld = o_rd_vld; end
        end
        next_cycle();
        i_reset = 1'b0;
        #2;
        checks += 4;
        if (pre_addr !== 11'd500 || pre_vld !== 1'b1) begin errors++; $display("FAIL rst_pre_addr: got addr %0d vld %b expected addr 500 vld 1", pre_addr, pre_vld); end
        if (o_rd_addr !== 11'd0 || o_rd_vld !== 1'b0 || o_rd_sop !== 1'b0 || o_rd_last !== 1'b0) begin errors++; $display("FAIL rst_rd_outputs: got addr %0d vld %b expected addr 0 vld 0", o_rd_addr, o_rd_vld); end
        if (o_busy !== 1'b0 || o_lane_ack !== 8'h00 || o_resort !== 1'b0 || o_ovf_err !== 1'b0 || o_timeout_err !== 1'b0) begin errors++; $display("FAIL rst_status_outputs: got busy %b ack %h expected busy 0 ack 00", o_busy, o_lane_ack); end
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #2;
            if (o_busy) restart_n++;
        end
        if (restart_n != 0) begin errors++; $display("FAIL rst_pend_cleared: got %0d busy cycles expected 0", restart_n); end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        i_reset     = 1'b1;
        i_enable    = 1'b0;
        i_lane_mask = 8'h00;
        i_dr_mode   = 2'd3;
        i_lane_rdy  = 8'h00;
        i_slot_idx  = 7'd0;
        i_symb_idx  = 4'd0;
        i_core_busy = 1'b0;
        test_reset();
        test_basic_sweep();
        test_stall();
        test_overflow();
        test_resort();
`ifdef PUSCH_DR_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_issue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
